// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like N-to-1 arbiter.
//   PRIO_FIXED / PRIO_RR : arbitration policy selectors
//   SIZE_*               : sram-like transfer size encodings
//   arb_state_t          : grant/lock state encoding
//   id_width()           : bits needed to index n items (never less than 1)
package sram_like_arbiter_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_like_id_fifo.sv
// In-order FIFO of master IDs for accepted-but-not-returned transactions.
//   clk, resetn       : clock, asynchronous active-low reset
//   push, push_data   : enqueue an ID (ignored when full)
//   pop               : dequeue the head (ignored when empty)
//   head              : oldest ID
//   count, full, empty: occupancy
module sram_like_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = id_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-master to 1-slave arbiter for the sram-like bus (req/addr_ok/data_ok).
// Responses are routed back in acceptance order via an ID FIFO.
//   clk, resetn                 : clock, asynchronous active-low reset
//   m_req/m_wr/m_size/m_wstrb/
//   m_addr/m_wdata              : packed per-master request channels
//   m_addr_ok, m_data_ok        : per-master handshakes
//   m_rdata                     : broadcast read data
//   s_*                         : slave port
//   outstanding                 : in-flight transaction count
//   err_unexpected              : sticky, s_data_ok with nothing in flight
//
// state     | meaning
// ST_IDLE   | grant follows the combinational arbiter
// ST_LOCKED | request offered but not accepted; grant held on lock_idx
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PRIO_MODE       = PRIO_FIXED
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_wr,
    input  logic [2*NUM_MASTERS-1:0]      m_size,
    input  logic [4*NUM_MASTERS-1:0]      m_wstrb,
    input  logic [32*NUM_MASTERS-1:0]     m_addr,
    input  logic [32*NUM_MASTERS-1:0]     m_wdata,
    output logic [NUM_MASTERS-1:0]        m_addr_ok,
    output logic [NUM_MASTERS-1:0]        m_data_ok,
    output logic [31:0]                   m_rdata,
    output logic                          s_req,
    output logic                          s_wr,
    output logic [1:0]                    s_size,
    output logic [3:0]                    s_wstrb,
    output logic [31:0]                   s_addr,
    output logic [31:0]                   s_wdata,
    input  logic                          s_addr_ok,
    input  logic                          s_data_ok,
    input  logic [31:0]                   s_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                          err_unexpected
);

    localparam int IDW = id_width(NUM_MASTERS);

    arb_state_t     state;
    logic [IDW-1:0] lock_idx;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] arb_grant;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] head;
    logic           found;
    logic           sel_req;
    logic           fifo_full;
    logic           fifo_empty;
    logic           accept;
    logic           ret;

    // Round-robin searches indices >= rr_ptr first, then wraps to the lower ones.
    always_comb begin
        arb_grant = '0;
        found     = 1'b0;
        if (PRIO_MODE == PRIO_RR) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!found && m_req[i] && (IDW'(i) >= rr_ptr)) begin
                    arb_grant = IDW'(i);
                    found     = 1'b1;
                end
            end
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!found && m_req[i]) begin
                    arb_grant = IDW'(i);
                    found     = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (m_req[i]) arb_grant = IDW'(i);
            end
        end
    end

    assign grant = (state == ST_LOCKED) ? lock_idx : arb_grant;

    always_comb begin
        sel_req = 1'b0;
        s_wr    = 1'b0;
        s_size  = '0;
        s_wstrb = '0;
        s_addr  = '0;
        s_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant == IDW'(i)) begin
                sel_req = m_req[i];
                s_wr    = m_wr[i];
                s_size  = m_size[2*i +: 2];
                s_wstrb = m_wstrb[4*i +: 4];
                s_addr  = m_addr[32*i +: 32];
                s_wdata = m_wdata[32*i +: 32];
            end
        end
    end

    // Full gating uses the registered count: a pop never frees a slot in the same cycle.
    assign s_req   = resetn & sel_req & ~fifo_full;
    assign accept  = s_req & s_addr_ok;
    assign ret     = resetn & s_data_ok & ~fifo_empty;
    assign m_rdata = s_rdata;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_addr_ok[i] = accept & (grant == IDW'(i));
            m_data_ok[i] = ret & (head == IDW'(i));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            lock_idx       <= '0;
            rr_ptr         <= '0;
            err_unexpected <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_req && !s_addr_ok) begin
                        state    <= ST_LOCKED;
                        lock_idx <= grant;
                    end
                end
                ST_LOCKED: begin
                    if (s_addr_ok) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (accept && (PRIO_MODE == PRIO_RR)) begin
                rr_ptr <= (grant == IDW'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
            end
            if (s_data_ok && fifo_empty) begin
                err_unexpected <= 1'b1;
            end
        end
    end

    sram_like_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (accept),
        .push_data (grant),
        .pop       (ret),
        .head      (head),
        .count     (outstanding),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [N-1:0]    m_req;
    logic [N-1:0]    m_wr;
    logic [2*N-1:0]  m_size;
    logic [4*N-1:0]  m_wstrb;
    logic [32*N-1:0] m_addr;
    logic [32*N-1:0] m_wdata;
    logic            s_addr_ok;
    logic            s_data_ok;
    logic [31:0]     s_rdata;

    logic [N-1:0] f_addr_ok, f_data_ok, r_addr_ok, r_data_ok;
    logic [31:0]  f_rdata, r_rdata, f_saddr, r_saddr, f_swdata, r_swdata;
    logic         f_sreq, r_sreq, f_swr, r_swr, f_err, r_err;
    logic [1:0]   f_ssize, r_ssize;
    logic [3:0]   f_swstrb, r_swstrb;
    logic [2:0]   f_out, r_out;

    sram_like_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MO), .PRIO_MODE(PRIO_FIXED)) u_fix (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(f_addr_ok), .m_data_ok(f_data_ok), .m_rdata(f_rdata),
        .s_req(f_sreq), .s_wr(f_swr), .s_size(f_ssize), .s_wstrb(f_swstrb),
        .s_addr(f_saddr), .s_wdata(f_swdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outstanding(f_out), .err_unexpected(f_err)
    );

    sram_like_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MO), .PRIO_MODE(PRIO_RR)) u_rr (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(r_addr_ok), .m_data_ok(r_data_ok), .m_rdata(r_rdata),
        .s_req(r_sreq), .s_wr(r_swr), .s_size(r_ssize), .s_wstrb(r_swstrb),
        .s_addr(r_saddr), .s_wdata(r_swdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outstanding(r_out), .err_unexpected(r_err)
    );

    int checks = 0;
    int errors = 0;
    int q_fix[$];
    int q_rr[$];

    typedef struct {
        logic [1:0]  req;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_sreq;
        logic [31:0] e_saddr;
        logic [1:0]  e_aok;
        logic [1:0]  e_dok;
        logic [2:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [1:0] req, input logic aok, input logic dok,
                                input logic [31:0] rdata, input logic e_sreq,
                                input logic [31:0] e_saddr, input logic [1:0] e_aok,
                                input logic [1:0] e_dok, input logic [2:0] e_out,
                                input logic e_err);
        vec_t v;
        v.req = req; v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.e_sreq = e_sreq; v.e_saddr = e_saddr; v.e_aok = e_aok;
        v.e_dok = e_dok; v.e_out = e_out; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        m_req     = '0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        s_rdata   = '0;
        q_fix.delete();
        q_rr.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
    endtask

    // One cycle of stimulus; ef/er are the master each DUT should accept (-1 = none).
    // Expected IDs are queued on accept and popped when s_data_ok is driven.
    task automatic step(input logic [1:0] req, input logic aok, input logic dok,
                        input logic [31:0] rd, input int ef, input int er);
        int id;
        logic [31:0] exp_f, exp_r;
        m_req = req; s_addr_ok = aok; s_data_ok = dok; s_rdata = rd;
        #2;
        chk("fix_outstanding", {29'd0, f_out}, q_fix.size());
        chk("rr_outstanding", {29'd0, r_out}, q_rr.size());
        chk("fix_addr_ok", {30'd0, f_addr_ok}, (ef < 0) ? 32'd0 : (32'd1 << ef));
        chk("rr_addr_ok", {30'd0, r_addr_ok}, (er < 0) ? 32'd0 : (32'd1 << er));
        exp_f = 32'd0;
        exp_r = 32'd0;
        if (dok && q_fix.size() > 0) begin
            id = q_fix.pop_front();
            exp_f = 32'd1 << id;
            chk("fix_rdata", f_rdata, rd);
        end
        if (dok && q_rr.size() > 0) begin
            id = q_rr.pop_front();
            exp_r = 32'd1 << id;
            chk("rr_rdata", r_rdata, rd);
        end
        chk("fix_data_ok", {30'd0, f_data_ok}, exp_f);
        chk("rr_data_ok", {30'd0, r_data_ok}, exp_r);
        if (ef >= 0) q_fix.push_back(ef);
        if (er >= 0) q_rr.push_back(er);
        tick();
    endtask

    initial begin
        m_wr    = 2'b10;
        m_size  = {SIZE_HALF, SIZE_WORD};
        m_wstrb = {4'b0011, 4'b1111};
        m_addr  = {32'h2000_0000, 32'h1c00_0000};
        m_wdata = {32'hcafe_0001, 32'h0000_0000};

        // reset values, with a request held during reset
        resetn = 1'b0; m_req = 2'b01; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = '0;
        #12;
        chk("rst_outstanding", {29'd0, f_out}, 32'd0);
        chk("rst_err", {31'd0, f_err}, 32'd0);
        chk("rst_sreq", {31'd0, f_sreq}, 32'd0);
        chk("rst_addr_ok", {30'd0, f_addr_ok}, 32'd0);
        chk("rst_data_ok", {30'd0, f_data_ok}, 32'd0);
        do_reset();

        // single read, full gating, drain, unexpected data_ok
        vt.push_back(mk(2'b01, 0, 0, 0,            1, 32'h1c00_0000, 2'b00, 2'b00, 0, 0));
        vt.push_back(mk(2'b01, 1, 0, 0,            1, 32'h1c00_0000, 2'b01, 2'b00, 0, 0));
        vt.push_back(mk(2'b00, 0, 0, 0,            0, 0,             2'b00, 2'b00, 1, 0));
        vt.push_back(mk(2'b00, 0, 1, 32'hdeadbeef, 0, 0,             2'b00, 2'b01, 1, 0));
        vt.push_back(mk(2'b00, 0, 0, 0,            0, 0,             2'b00, 2'b00, 0, 0));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(2'b01, 1, 0, 0, 1, 32'h1c00_0000, 2'b01, 2'b00, 3'(k), 0));
        vt.push_back(mk(2'b01, 1, 0, 0,            0, 0,             2'b00, 2'b00, 4, 0));
        vt.push_back(mk(2'b01, 1, 1, 32'h1111_1111, 0, 0,            2'b00, 2'b01, 4, 0));
        vt.push_back(mk(2'b01, 0, 0, 0,            1, 32'h1c00_0000, 2'b00, 2'b00, 3, 0));
        vt.push_back(mk(2'b01, 1, 0, 0,            1, 32'h1c00_0000, 2'b01, 2'b00, 3, 0));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(2'b00, 0, 1, 32'h100 + k, 0, 0, 2'b00, 2'b01, 3'(4 - k), 0));
        vt.push_back(mk(2'b00, 0, 0, 0,            0, 0,             2'b00, 2'b00, 0, 0));
        vt.push_back(mk(2'b00, 0, 1, 32'h5555,     0, 0,             2'b00, 2'b00, 0, 0));
        vt.push_back(mk(2'b00, 0, 0, 0,            0, 0,             2'b00, 2'b00, 0, 1));

        foreach (vt[k]) begin
            m_req = vt[k].req; s_addr_ok = vt[k].aok; s_data_ok = vt[k].dok; s_rdata = vt[k].rdata;
            #2;
            chk($sformatf("v%0d_sreq", k), {31'd0, f_sreq}, {31'd0, vt[k].e_sreq});
            if (vt[k].e_sreq) chk($sformatf("v%0d_saddr", k), f_saddr, vt[k].e_saddr);
            chk($sformatf("v%0d_addr_ok", k), {30'd0, f_addr_ok}, {30'd0, vt[k].e_aok});
            chk($sformatf("v%0d_data_ok", k), {30'd0, f_data_ok}, {30'd0, vt[k].e_dok});
            if (vt[k].e_dok != 0) chk($sformatf("v%0d_rdata", k), f_rdata, vt[k].rdata);
            chk($sformatf("v%0d_outstanding", k), {29'd0, f_out}, {29'd0, vt[k].e_out});
            chk($sformatf("v%0d_err", k), {31'd0, f_err}, {31'd0, vt[k].e_err});
            tick();
        end

        // contention: fixed 0,0,0,0 / round-robin 0,1,0,1, then full, then drain
        do_reset();
        step(2'b11, 1, 0, 0, 0, 0);
        step(2'b11, 1, 0, 0, 0, 1);
        step(2'b11, 1, 0, 0, 0, 0);
        step(2'b11, 1, 0, 0, 0, 1);
        step(2'b11, 1, 0, 0, -1, -1);
        for (int k = 0; k < 4; k++) step(2'b00, 0, 1, 32'ha000 + k, -1, -1);
        step(2'b00, 0, 0, 0, -1, -1);

        // lock: master1 held three cycles while master0 joins
        do_reset();
        m_req = 2'b10; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        #2;
        chk("lock_saddr_f", f_saddr, 32'h2000_0000);
        chk("lock_saddr_r", r_saddr, 32'h2000_0000);
        chk("lock_swdata", f_swdata, 32'hcafe_0001);
        chk("lock_swr", {31'd0, f_swr}, 32'd1);
        chk("lock_ssize", {30'd0, f_ssize}, {30'd0, SIZE_HALF});
        chk("lock_swstrb", {28'd0, f_swstrb}, 32'h3);
        chk("lock_rr_attrs", {r_swdata[7:0], 21'd0, r_swr, r_ssize, r_swstrb}, {8'h01, 21'd0, 1'b1, SIZE_HALF, 4'b0011});
        tick();
        for (int k = 0; k < 2; k++) begin
            m_req = 2'b11;
            #2;
            chk("lock_hold_saddr_f", f_saddr, 32'h2000_0000);
            chk("lock_hold_saddr_r", r_saddr, 32'h2000_0000);
            chk("lock_hold_aok", {30'd0, f_addr_ok}, 32'd0);
            tick();
        end
        s_addr_ok = 1'b1;
        #2;
        chk("lock_acc_saddr", f_saddr, 32'h2000_0000);
        chk("lock_acc_aok_f", {30'd0, f_addr_ok}, 32'h2);
        chk("lock_acc_aok_r", {30'd0, r_addr_ok}, 32'h2);
        q_fix.push_back(1); q_rr.push_back(1);
        tick();
        m_req = 2'b01;
        #2;
        chk("lock_next_saddr", f_saddr, 32'h1c00_0000);
        chk("lock_next_aok_f", {30'd0, f_addr_ok}, 32'h1);
        chk("lock_next_aok_r", {30'd0, r_addr_ok}, 32'h1);
        q_fix.push_back(0); q_rr.push_back(0);
        tick();
        step(2'b00, 0, 1, 32'h0a, -1, -1);
        step(2'b00, 0, 1, 32'h0b, -1, -1);

        // ordering: accepts m1,m0,m1 with one return coincident with an accept
        do_reset();
        step(2'b10, 1, 0, 0, 1, 1);
        step(2'b01, 1, 0, 0, 0, 0);
        step(2'b00, 0, 1, 32'h0001_0001, -1, -1);
        step(2'b10, 1, 1, 32'h0002_0002, 1, 1);
        step(2'b00, 0, 1, 32'h0003_0003, -1, -1);
        step(2'b00, 0, 0, 0, -1, -1);

        // unexpected data_ok, then reset mid-cycle with two in flight
        step(2'b00, 0, 1, 32'h5, -1, -1);
        m_req = 2'b00; s_data_ok = 1'b0;
        #2;
        chk("err_set_f", {31'd0, f_err}, 32'd1);
        chk("err_set_r", {31'd0, r_err}, 32'd1);
        tick();
        step(2'b01, 1, 0, 0, 0, 0);
        step(2'b01, 1, 0, 0, 0, 0);
        m_req = 2'b11; s_addr_ok = 1'b0;
        #3;
        chk("pre_rst_outstanding", {29'd0, f_out}, 32'd2);
        resetn = 1'b0;
        #1;
        chk("mid_rst_outstanding_f", {29'd0, f_out}, 32'd0);
        chk("mid_rst_outstanding_r", {29'd0, r_out}, 32'd0);
        chk("mid_rst_err", {31'd0, f_err}, 32'd0);
        chk("mid_rst_sreq_f", {31'd0, f_sreq}, 32'd0);
        chk("mid_rst_sreq_r", {31'd0, r_sreq}, 32'd0);
        q_fix.delete(); q_rr.delete();
        m_req = '0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
